// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle processor main control FSM (fetch/decode/execute/memory/writeback)
// Optional ERROR trap state for op=11 enabled by defining ILLEGAL_TRAP_EN.
module multicycle_main_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         op,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               next_pc,
   output logic               adr_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               alu_op,
   output logic [1:0]         result_src,
   output logic               reg_w,
   output logic               mem_w,
   output logic               branch,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = STATE_W'(0),
      S_DECODE = STATE_W'(1),
      S_MEMADR = STATE_W'(2),
      S_MEMRD  = STATE_W'(3),
      S_MEMWB  = STATE_W'(4),
      S_MEMWR  = STATE_W'(5),
      S_EXECR  = STATE_W'(6),
      S_EXECI  = STATE_W'(7),
      S_ALUWB  = STATE_W'(8),
      S_BRANCH = STATE_W'(9)
`ifdef ILLEGAL_TRAP_EN
      , S_ERROR = STATE_W'(10)
`endif
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   state_t state_q;

   // Only the I and L/S bits steer the sequence; the rest of funct belongs to the ALU decoder.
   logic unused_funct;
   assign unused_funct = &{1'b0, funct[4:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:  if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_DP:   state_q <= funct[5] ? S_EXECI : S_EXECR;
                  OP_MEM:  state_q <= S_MEMADR;
                  OP_BR:   state_q <= S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                  default: state_q <= S_ERROR;
`else
                  default: state_q <= S_FETCH;
`endif
               endcase
            end
            S_MEMADR: state_q <= funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
            S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
            S_MEMWB:  state_q <= S_FETCH;
            S_EXECR:  state_q <= S_ALUWB;
            S_EXECI:  state_q <= S_ALUWB;
            S_ALUWB:  state_q <= S_FETCH;
            S_BRANCH: state_q <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_ERROR:  state_q <= S_ERROR;
`endif
            default:  state_q <= S_FETCH;
         endcase
      end
   end

   // Moore decode; only the fetch strobes also look at mem_ready.
   always_comb begin
      ir_write   = 1'b0;
      next_pc    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 1'b0;
      result_src = 2'b00;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            next_pc    = mem_ready;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = 2'b01;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECR: alu_op = 1'b1;
         S_EXECI: begin
            alu_src_b = 2'b01;
            alu_op    = 1'b1;
         end
         S_ALUWB:  reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
`ifdef ILLEGAL_TRAP_EN
         S_ERROR:  illegal = 1'b1;
`endif
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - directed self-checking bench for multicycle_main_fsm
// Covers the ILLEGAL_TRAP_EN build as well as the default build.
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] op;
   logic [5:0] funct;
   logic       mem_ready;
   logic       ir_write, next_pc, adr_src, alu_src_a, alu_op;
   logic [1:0] alu_src_b, result_src;
   logic       reg_w, mem_w, branch, illegal;
   logic [3:0] state;

   int vec_count  = 0;
   int miss_count = 0;

   multicycle_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .ir_write(ir_write), .next_pc(next_pc), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .reg_w(reg_w), .mem_w(mem_w), .branch(branch),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      assert (obs === exp) else begin
         miss_count++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = 2'b00; funct = 6'b000000; mem_ready = 1'b0;
      #12;
      // reset with mem_ready low: FETCH outputs, no fetch strobes
      chk("rst_state", state, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_next_pc", next_pc, 0);
      chk("rst_alu_src_a", alu_src_a, 1);
      chk("rst_alu_src_b", alu_src_b, 2);
      chk("rst_result_src", result_src, 2);
      chk("rst_wr_en", {reg_w, mem_w, branch, illegal, alu_op, adr_src}, 0);
      mem_ready = 1'b1;
      #1;
      chk("rst_ir_write_rdy", ir_write, 1);

      // data-processing register: 0,1,6,8,0
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("dp_s0", state, 0);
      chk("dp_s0_irw", ir_write, 1);
      tick(); chk("dp_s1", state, 1); chk("dp_s1_irw", ir_write, 0); chk("dp_s1_aluop", alu_op, 0);
      tick(); chk("dp_s6", state, 6); chk("dp_s6_aluop", alu_op, 1); chk("dp_s6_srcb", alu_src_b, 0);
      chk("dp_s6_regw", reg_w, 0);
      tick(); chk("dp_s8", state, 8); chk("dp_s8_regw", reg_w, 1); chk("dp_s8_aluop", alu_op, 0);
      chk("dp_s8_res", result_src, 0);
      tick(); chk("dp_back", state, 0); chk("dp_back_regw", reg_w, 0);

      // load: 0,1,2,3,4,0
      op = 2'b01; funct = 6'b011001;
      tick(); chk("ld_s1", state, 1);
      tick(); chk("ld_s2", state, 2); chk("ld_s2_srcb", alu_src_b, 1); chk("ld_s2_srca", alu_src_a, 0);
      tick(); chk("ld_s3", state, 3); chk("ld_s3_adr", adr_src, 1);
      tick(); chk("ld_s4", state, 4); chk("ld_s4_res", result_src, 1); chk("ld_s4_regw", reg_w, 1);
      tick(); chk("ld_back", state, 0);

      // store with three wait cycles in MEMWR
      funct = 6'b011000;
      tick(); chk("st_s1", state, 1);
      tick(); chk("st_s2", state, 2);
      tick(); chk("st_s5", state, 5); chk("st_s5_memw", mem_w, 1); chk("st_s5_adr", adr_src, 1);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_hold", state, 5);
         chk("st_hold_memw", mem_w, 1);
      end
      mem_ready = 1'b1;
      tick(); chk("st_back", state, 0); chk("st_back_memw", mem_w, 0);

      // FETCH stalls while memory is not ready
      mem_ready = 1'b0;
      #1; chk("fetch_wait_irw", ir_write, 0);
      tick(); chk("fetch_wait", state, 0);
      mem_ready = 1'b1;

      // branch: 0,1,9,0
      op = 2'b10; funct = 6'b000000;
      tick(); chk("br_s1", state, 1); chk("br_s1_br", branch, 0);
      tick(); chk("br_s9", state, 9); chk("br_s9_br", branch, 1); chk("br_s9_srcb", alu_src_b, 1);
      chk("br_s9_res", result_src, 2);
      tick(); chk("br_back", state, 0); chk("br_back_br", branch, 0);

      // async reset while in EXECI
      op = 2'b00; funct = 6'b100000;
      tick(); chk("ei_s1", state, 1);
      tick(); chk("ei_s7", state, 7); chk("ei_s7_aluop", alu_op, 1); chk("ei_s7_srcb", alu_src_b, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_aluop", alu_op, 0);
      @(negedge clk); rst_n = 1'b1;
      op = 2'b11; funct = 6'b000000;
      tick(); chk("post_rst_s1", state, 1);

      // unsupported op
      tick();
`ifdef ILLEGAL_TRAP_EN
      chk("ill_state", state, 10);
      chk("ill_flag", illegal, 1);
      op = 2'b00;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("ill_hold", state, 10);
         chk("ill_hold_flag", illegal, 1);
         chk("ill_hold_wr", {reg_w, mem_w, branch}, 0);
      end
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("ill_rst_state", state, 0);
      chk("ill_rst_flag", illegal, 0);
      @(negedge clk); rst_n = 1'b1;
`else
      chk("nop_state", state, 0);
      chk("nop_flag", illegal, 0);
      tick(); chk("nop_next", state, 1); chk("nop_next_flag", illegal, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
